// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic IFU = 1'b0;
    localparam logic LSU = 1'b1;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant with last-grant memory
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_valid,
    output logic       grant
);

    logic last_grant;

    // On a tie the master that did not win last time gets the grant
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1] ? LSU : IFU;
        end
    end

    // Remember the winner; reset leaves LSU as last winner so IFU wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= LSU;
        end else if (update && grant_valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between the fetch and load/store masters
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_ifu_req_valid,
    output logic                o_ifu_req_ready,
    input  logic [ADDR_W-1:0]   i_ifu_addr,
    output logic                o_ifu_resp_valid,
    output logic [DATA_W-1:0]   o_ifu_rdata,
    output logic                o_ifu_err,
    input  logic                i_lsu_req_valid,
    output logic                o_lsu_req_ready,
    input  logic [ADDR_W-1:0]   i_lsu_addr,
    input  logic                i_lsu_wen,
    input  logic [DATA_W-1:0]   i_lsu_wdata,
    input  logic [DATA_W/8-1:0] i_lsu_wmask,
    output logic                o_lsu_resp_valid,
    output logic [DATA_W-1:0]   o_lsu_rdata,
    output logic                o_lsu_err,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic                i_mem_resp_valid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    input  logic                i_mem_err
);

    localparam int          STRB_W     = DATA_W / 8;
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    state_t              state;
    state_t              state_next;
    logic                owner;
    logic [15:0]         tcount;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_wen;
    logic [DATA_W-1:0]   req_wdata;
    logic [STRB_W-1:0]   req_wmask;

    logic                in_idle;
    logic                grant_valid;
    logic                grant;
    logic                timeout_hit;
    logic                resp_fire;
    logic [DATA_W-1:0]   resp_rdata;
    logic                resp_err;

    assign in_idle     = (state == IDLE);
    assign timeout_hit = (tcount == TIMEOUT_M1);
    assign resp_fire   = (state == RESP) && (i_mem_resp_valid || timeout_hit);

    rr_arbiter2 u_rr (
        .clk         (i_clock),
        .reset       (i_reset),
        .req         (in_idle ? {i_lsu_req_valid, i_ifu_req_valid} : 2'b00),
        .update      (in_idle),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: grant -> wait for memory accept -> wait for response or timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid)     state_next = REQ;
            REQ:     if (i_mem_req_ready) state_next = RESP;
            RESP:    if (resp_fire)       state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // Request latches, owner and response timeout counter
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            owner     <= IFU;
            tcount    <= '0;
            req_addr  <= '0;
            req_wen   <= 1'b0;
            req_wdata <= '0;
            req_wmask <= '0;
        end else begin
            if (in_idle && grant_valid) begin
                owner     <= grant;
                req_addr  <= (grant == LSU) ? i_lsu_addr : i_ifu_addr;
                req_wen   <= (grant == LSU) && i_lsu_wen;
                req_wdata <= (grant == LSU) ? i_lsu_wdata : '0;
                req_wmask <= (grant == LSU) ? i_lsu_wmask : '0;
            end
            if (state == REQ && i_mem_req_ready) begin
                tcount <= '0;
            end else if (state == RESP) begin
                tcount <= tcount + 16'd1;
            end
        end
    end

    // Response payload: real response wins over timeout; stores return zero data
    always_comb begin
        resp_rdata = '0;
        resp_err   = 1'b1;
        if (i_mem_resp_valid) begin
            resp_rdata = req_wen ? '0 : i_mem_rdata;
            resp_err   = i_mem_err;
        end
    end

    // Outputs; everything handshake-related is held quiet while reset is asserted
    always_comb begin
        o_ifu_req_ready  = !i_reset && in_idle && grant_valid && (grant == IFU);
        o_lsu_req_ready  = !i_reset && in_idle && grant_valid && (grant == LSU);
        o_mem_req_valid  = !i_reset && (state == REQ);
        o_mem_addr       = req_addr;
        o_mem_wen        = req_wen;
        o_mem_wdata      = req_wdata;
        o_mem_wmask      = req_wmask;
        o_ifu_resp_valid = 1'b0;
        o_ifu_rdata      = '0;
        o_ifu_err        = 1'b0;
        o_lsu_resp_valid = 1'b0;
        o_lsu_rdata      = '0;
        o_lsu_err        = 1'b0;
        if (!i_reset && resp_fire) begin
            if (owner == IFU) begin
                o_ifu_resp_valid = 1'b1;
                o_ifu_rdata      = resp_rdata;
                o_ifu_err        = resp_err;
            end else begin
                o_lsu_resp_valid = 1'b1;
                o_lsu_rdata      = resp_rdata;
                o_lsu_err        = resp_err;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one simple memory port between the instruction fetch unit (read-only master) and the load/store unit (read/write master) in the multi-cycle RV32E core.
- Decides arbitration with round-robin priority.
- Latches the winning request and drives it to memory until memory accepts it.
- Routes the single outstanding response back to the owner; a response that never arrives is converted into an error response after a timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles in RESP before forcing an error response (1..2^16-1)

Ports:
i_clock  in  1  core clock
i_reset  in  1  synchronous, active-high reset
i_ifu_req_valid  in  1  fetch request
o_ifu_req_ready  out  1  fetch request accepted this cycle
i_ifu_addr  in  ADDR_W  fetch address
o_ifu_resp_valid  out  1  fetch response pulse
o_ifu_rdata  out  DATA_W  fetched instruction
o_ifu_err  out  1  fetch bus error/timeout
i_lsu_req_valid  in  1  load/store request
o_lsu_req_ready  out  1  load/store request accepted this cycle
i_lsu_addr  in  ADDR_W  load/store address
i_lsu_wen  in  1  1 = store
i_lsu_wdata  in  DATA_W  store data
i_lsu_wmask  in  DATA_W/8  byte strobes
o_lsu_resp_valid  out  1  load/store response pulse
o_lsu_rdata  out  DATA_W  load data (0 for stores)
o_lsu_err  out  1  load/store bus error/timeout
o_mem_req_valid  out  1  request to memory
i_mem_req_ready  in  1  memory accepts request
o_mem_addr  out  ADDR_W  latched address
o_mem_wen  out  1  latched write enable
o_mem_wdata  out  DATA_W  latched write data
o_mem_wmask  out  DATA_W/8  latched strobes
i_mem_resp_valid  in  1  memory response
i_mem_rdata  in  DATA_W  memory read data
i_mem_err  in  1  memory error

Behaviour:
- Clock and reset: one clock, i_clock. Reset i_reset is synchronous and active-high.
- On reset:
  - state = IDLE, owner = IFU, last_grant = LSU (so IFU wins the first tie), timeout counter = 0.
  - All latched request registers = 0.
  - All valid, ready and err outputs = 0.
- Reset mid-transaction: the transaction is abandoned. No response pulse is issued to either master. A memory response arriving after reset is ignored.
- State machine has three states:
  - IDLE: the grant is combinational.
    - Only one master's valid is set: that master is granted.
    - Both valid: the master other than last_grant is granted.
    - The granted master's o_*_req_ready = 1 for that cycle only.
    - At the clock edge, the master's addr/wen/wdata/wmask are latched into the request registers. IFU requests latch wen = 0, wmask = 0, wdata = 0.
    - owner and last_grant are set to the granted master, and the FSM moves to REQ.
    - With no valid request, the FSM stays in IDLE.
  - REQ:
    - o_mem_req_valid = 1, driven from the latched registers; the registers stay stable while waiting.
    - i_mem_req_ready = 1 moves to RESP and clears the counter.
    - No timeout in REQ.
  - RESP:
    - The counter increments each cycle.
    - If i_mem_resp_valid = 1: o_<owner>_resp_valid = 1 in the same cycle (combinational). rdata = i_mem_rdata, err = i_mem_err. Go to IDLE.
    - Else, if the counter equals TIMEOUT-1: o_<owner>_resp_valid = 1 with err = 1 and rdata = 0. Go to IDLE.
    - A response arriving in the timeout cycle takes precedence over the timeout.
- Latency:
  - req_ready in cycle N, o_mem_req_valid from N+1.
  - Minimum round trip is 3 cycles: IDLE, REQ with ready, RESP with response.
  - The earliest new grant is the cycle after the response.
- Stray inputs: i_mem_resp_valid in IDLE or REQ is ignored. i_mem_req_ready outside REQ is ignored.
- The non-owner's resp_valid and err are always 0. rdata outputs are 0 when their resp_valid = 0.
- Masters must hold req_valid and payload until ready. Masters always accept responses; there is no resp_ready.
- Only one transaction is outstanding at a time.

Decomposition:
- Shared package holds:
  - State encoding: IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2.
  - Master ID constants: IFU = 1'b0, LSU = 1'b1.
  - Default TIMEOUT.
- One sub-module, rr_arbiter2: a 2-input round-robin grant with a last_grant register and an update enable.
- The FSM, request latches and timeout counter stay in mem_arbiter.

Test Plan:
- IFU only, addr 0x80000000, mem ready immediately, resp 1 cycle later with rdata 0x00000413 -> ifu_req_ready in cycle 0, mem_req_valid in cycle 1, ifu_resp_valid with rdata 0x00000413 in cycle 2, lsu_resp_valid stays 0.
- Both requesters valid after reset -> IFU granted first. Both still valid afterwards -> LSU granted next, then IFU (strict alternation over 4 transactions).
- LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011, mem req_ready held low 5 cycles -> mem_req_valid/addr/wdata/wmask stable for all 6 cycles, and LSU payload changes after its accept do not leak to the mem outputs.
- TIMEOUT = 4, no memory response -> owner resp_valid = 1 with err = 1 and rdata = 0 on the 4th RESP cycle. A late i_mem_resp_valid in the next cycle is ignored.
- i_mem_err = 1 with the LSU load response -> lsu_err = 1, rdata passed through. The next transaction's err = 0.
- i_reset asserted during RESP -> outputs 0 next cycle, state IDLE, no response pulse. A subsequent IFU request completes normally.
